// File: rtl/atm_txn_sequencer.sv
// ATM transaction sequencer: confirms a deposit/withdraw request, reads the
// selected account, validates it, commits the new balance with a one-cycle
// write enable and holds a result code for the display.
// Optional feature: define WDRAW_LIMIT_EN to enable the per-withdrawal limit
// check (status 5) against MAX_WDRAW.
module atm_txn_sequencer #(
  parameter logic [31:0] MAX_BAL = 32'd99999999,
  parameter logic [15:0] HOLD_MS = 16'd2000
`ifdef WDRAW_LIMIT_EN
  ,
  parameter logic [31:0] MAX_WDRAW = 32'd500
`endif
) (
  input  logic        sclk_1ms,
  input  logic        rst,
  input  logic [1:0]  sel_mode,
  input  logic [3:0]  sel_reg,
  input  logic        flag,
  input  logic [31:0] amount,
  input  logic [31:0] rd_data,
  output logic [3:0]  rf_sel,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status
);

  typedef enum logic [2:0] {StIdle, StRead, StCheck, StWrite, StHold} state_e;

  localparam logic [2:0] StatIdle  = 3'd0;
  localparam logic [2:0] StatOk    = 3'd1;
  localparam logic [2:0] StatNsf   = 3'd2;
  localparam logic [2:0] StatOvf   = 3'd3;
  localparam logic [2:0] StatZero  = 3'd4;
`ifdef WDRAW_LIMIT_EN
  localparam logic [2:0] StatLimit = 3'd5;
`endif

  state_e      state_q, state_d;
  logic [2:0]  flag_sync_q;
  logic        wdraw_q, wdraw_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] amt_q, amt_d;
  logic [31:0] bal_q, bal_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  status_q, status_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        done_q, done_d;
  logic        confirm;
  logic        mode_valid;
  logic [32:0] sum;

  // Two flops resynchronise the slow button level; the third gives rise detect.
  always_ff @(posedge sclk_1ms or posedge rst) begin
    if (rst) begin
      flag_sync_q <= '0;
    end else begin
      flag_sync_q <= {flag_sync_q[1:0], flag};
    end
  end

  assign confirm    = flag_sync_q[1] & ~flag_sync_q[2];
  assign mode_valid = (sel_mode == 2'b01) || (sel_mode == 2'b10);
  // 33-bit sum so a deposit cannot wrap past the ceiling check.
  assign sum        = {1'b0, bal_q} + {1'b0, amt_q};

  // State and transaction registers.
  always_ff @(posedge sclk_1ms or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wdraw_q    <= 1'b0;
      idx_q      <= '0;
      amt_q      <= '0;
      bal_q      <= '0;
      wdata_q    <= '0;
      status_q   <= StatIdle;
      hold_cnt_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wdraw_q    <= wdraw_d;
      idx_q      <= idx_d;
      amt_q      <= amt_d;
      bal_q      <= bal_d;
      wdata_q    <= wdata_d;
      status_q   <= status_d;
      hold_cnt_q <= hold_cnt_d;
      done_q     <= done_d;
    end
  end

  // Next-state: capture, read, check, write, hold.
  always_comb begin
    state_d    = state_q;
    wdraw_d    = wdraw_q;
    idx_d      = idx_q;
    amt_d      = amt_q;
    bal_d      = bal_q;
    wdata_d    = wdata_q;
    status_d   = status_q;
    hold_cnt_d = '0;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        // Confirms with show/reserved modes are ignored.
        if (confirm && mode_valid) begin
          wdraw_d = sel_mode[1];
          idx_d   = sel_reg;
          amt_d   = amount;
          state_d = StRead;
        end
      end
      StRead: begin
        bal_d   = rd_data;
        state_d = StCheck;
      end
      StCheck: begin
        state_d = StHold;
        done_d  = 1'b1;
        if (amt_q == '0) begin
          status_d = StatZero;
`ifdef WDRAW_LIMIT_EN
        end else if (wdraw_q && (amt_q > MAX_WDRAW)) begin
          status_d = StatLimit;
`endif
        end else if (!wdraw_q && (sum > {1'b0, MAX_BAL})) begin
          status_d = StatOvf;
        end else if (wdraw_q && (amt_q > bal_q)) begin
          status_d = StatNsf;
        end else begin
          status_d = StatOk;
          wdata_d  = wdraw_q ? (bal_q - amt_q) : sum[31:0];
          state_d  = StWrite;
          done_d   = 1'b0;
        end
      end
      StWrite: begin
        state_d = StHold;
        done_d  = 1'b1;
      end
      StHold: begin
        if (hold_cnt_q == HOLD_MS - 16'd1) begin
          state_d  = StIdle;
          status_d = StatIdle;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; write enable is decoded from state so reset drops it at once.
  always_comb begin
    rf_sel   = (state_q == StIdle) ? sel_reg : idx_q;
    rf_we    = (state_q == StWrite);
    rf_wdata = wdata_q;
    busy     = (state_q != StIdle);
    done     = done_q;
    status   = status_q;
  end

endmodule
